// File: rtl/mem_master.sv
// Single-port memory master: host requests become registered mem_we/mem_addr cycles on a shared tri-state bus.
// Define MEM_MASTER_VERIFY_EN to read back every write and flag mismatches on rsp_err.
module mem_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_CAP
`ifdef MEM_MASTER_VERIFY_EN
        ,
        VFY_ADDR,
        VFY_CAP
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef MEM_MASTER_VERIFY_EN
    logic                rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_MASTER_VERIFY_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_d = req_addr;
                    wdata_d    = req_wdata;
                    mem_we_d   = req_we;
                    state_d    = req_we ? WR : RD_ADDR;
                end
            end
            WR: begin
                mem_we_d = 1'b0;
`ifdef MEM_MASTER_VERIFY_EN
                state_d  = VFY_ADDR;
`else
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
`endif
            end
            RD_ADDR: state_d = RD_CAP;
            RD_CAP: begin
                rsp_rdata_d = mem_data;
                rsp_valid_d = 1'b1;
`ifdef MEM_MASTER_VERIFY_EN
                rsp_err_d   = 1'b0;
`endif
                state_d     = IDLE;
            end
`ifdef MEM_MASTER_VERIFY_EN
            VFY_ADDR: state_d = VFY_CAP;
            VFY_CAP: begin
                rsp_rdata_d = mem_data;
                rsp_err_d   = (mem_data != wdata_q);
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef MEM_MASTER_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_MASTER_VERIFY_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // The bus is driven only by the registered write enable, so reset releases it at once.
    assign mem_data  = mem_we_q ? wdata_q : 'z;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
`ifdef MEM_MASTER_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  host request present.
REQ-006 SHALL have port req_ready  output  1  request accepted at this edge when high together with req_valid.
REQ-007 SHALL have port req_we  input  1  request type: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  target word address.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  read data, held until the next read completes.
REQ-012 SHALL have port rsp_err  output  1  write-verify mismatch; constant 0 without MEM_MASTER_VERIFY_EN.
REQ-013 SHALL have port mem_we  output  1  memory write enable, registered.
REQ-014 SHALL have port mem_addr  output  ADDR_W  memory address, registered.
REQ-015 SHALL have port mem_data  inout  DATA_W  shared tri-state data bus.

Function
REQ-016 SHALL implement the states IDLE, WR, RD_ADDR, RD_CAP, and also VFY_ADDR and VFY_CAP when MEM_MASTER_VERIFY_EN is defined.
REQ-017 SHALL drive req_ready = 1 only in IDLE, decoded combinationally from the state.
REQ-018 SHALL, on acceptance (edge T), register addr/wdata/we, load mem_addr, set mem_we = req_we, and go to WR if we = 1, else RD_ADDR.
REQ-019 SHALL drive mem_data from the registered wdata only while mem_we = 1, and release it to high-Z otherwise; no other drive condition is permitted.
REQ-020 SHALL, in WR, let the memory sample the data at edge T+1, clear mem_we at that edge, pulse rsp_valid during cycle T+1..T+2, and return to IDLE.
REQ-021 SHALL, in RD_ADDR, hold mem_we = 0 so the memory latches the word at edge T+1, then move to RD_CAP.
REQ-022 SHALL, in RD_CAP, sample mem_data into rsp_rdata at edge T+2, pulse rsp_valid during cycle T+2..T+3, and return to IDLE.
REQ-023 SHALL leave rsp_rdata unchanged on a write response.
REQ-024 SHALL support back-to-back operation: a request presented while rsp_valid is high is accepted at that same edge.
REQ-025 SHALL ignore req_* inputs while not in IDLE.
REQ-026 SHALL treat address wrap as a non-issue: req_addr is used modulo 2^ADDR_W, with no range check.
REQ-027 SHALL never assert rsp_valid for more than one consecutive cycle per request.

Reset
REQ-028 SHALL, while rst_n = 0 (asynchronously), set state to IDLE and set mem_we, mem_addr, rsp_valid, rsp_rdata and rsp_err to 0, releasing mem_data to high-Z immediately.
REQ-029 SHALL, on reset mid-operation, abort the operation with no rsp_valid; a write whose mem_we was dropped before its edge is not performed.
REQ-030 SHALL make req_ready = 1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, with MEM_MASTER_VERIFY_EN defined, go from WR to VFY_ADDR (read of the same address), then VFY_CAP, instead of responding from WR.
REQ-032 SHALL, in that mode, capture the read-back value into rsp_rdata at edge T+3, set rsp_err = (read-back != written data), pulse rsp_valid in cycle T+3..T+4, and hold rsp_err until the next response.
REQ-033 SHALL, without MEM_MASTER_VERIFY_EN, omit the VFY states, give a write latency of 1 cycle, and tie rsp_err to 0.

Verification
REQ-034 Bench SHALL instantiate the team's 32x8 data memory on mem_we/mem_addr/mem_data and check no bus contention (never X on mem_data while mem_we = 1).
REQ-035 Scenario: write addr 5 = 8'hA5, then read addr 5 -> write rsp_valid one cycle after acceptance; read rsp_valid two cycles after acceptance with rsp_rdata = 8'hA5.
REQ-036 Scenario: back-to-back writes to addr 0..31 with data = addr^8'h3C, then reads of addr 31 down to 0 -> every rsp_rdata matches, and req_ready is low only during busy states.
REQ-037 Scenario: req_valid held high with changing req_addr during RD_ADDR/RD_CAP -> only the accepted address is read; the extra values are ignored.
REQ-038 Scenario: rst_n pulled low in WR (write 8'hFF to addr 9, previously 8'h11) -> mem_we drops immediately, no rsp_valid, and a later read of addr 9 returns 8'h11.
REQ-039 Scenario (MEM_MASTER_VERIFY_EN): write 8'h5A to addr 3 with a stuck bit injected in the memory model -> rsp_valid at T+3 with rsp_err = 1; a clean write gives rsp_err = 0 and rsp_rdata = 8'h5A.
